// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one GCD core among N_REQ requesters.
// Zero operands bypass the core; a hung core is timed out with rsp_error.
module gcd_arbiter #(
  parameter int WIDTH          = 8,
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_error,
  output logic                   busy,
  output logic                   core_start,
  output logic [WIDTH-1:0]       core_a,
  output logic [WIDTH-1:0]       core_b,
  input  logic                   core_done,
  input  logic [WIDTH-1:0]       core_result,
  output logic [1:0]             dbg_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Handshake: a request transfers in the IDLE cycle where req_valid[i] and
  // req_ready[i] are both high; rsp_valid is a one-cycle pulse with no backpressure.
  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   grant;
  logic [CW-1:0]   cnt;
  logic            win;
  logic [PW-1:0]   win_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  int              j;

  // Scan from the highest offset down so the nearest requester after ptr wins.
  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_REQ;
      if (req_valid[j]) begin
        win     = 1'b1;
        win_idx = PW'(j);
      end
    end
  end

  assign sel_a     = req_a[int'(win_idx)*WIDTH +: WIDTH];
  assign sel_b     = req_b[int'(win_idx)*WIDTH +: WIDTH];
  assign req_ready = (state == IDLE && win && !reset) ? (N_REQ'(1) << win_idx) : '0;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      grant      <= '0;
      cnt        <= '0;
      core_start <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
    end else begin
      core_start <= 1'b0;
      rsp_valid  <= '0;
      case (state)
        IDLE: begin
          if (win) begin
            grant <= win_idx;
            ptr   <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
            if (sel_a == '0 || sel_b == '0) begin
              // gcd(0,x) = x, and gcd(0,0) = 0, so OR gives the answer directly.
              rsp_valid  <= N_REQ'(1) << win_idx;
              rsp_result <= sel_a | sel_b;
              rsp_error  <= 1'b0;
              state      <= RESP;
            end else begin
              core_a     <= sel_a;
              core_b     <= sel_b;
              core_start <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          // cnt == 0 marks the first WAIT cycle, where a stale done is ignored.
          if (core_done && cnt != '0) begin
            rsp_valid  <= N_REQ'(1) << grant;
            rsp_result <= core_result;
            rsp_error  <= 1'b0;
            state      <= RESP;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid  <= N_REQ'(1) << grant;
            rsp_result <= '0;
            rsp_error  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          rsp_result <= '0;
          rsp_error  <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
Shares one GCD core (start/done/a/b/result interface) among N_REQ requesters. Round-robin arbitration, operand latching and start pulsing. Routes the result back to the winning requester. Handles zero operands without the core and times out a hung core. Sits between client logic and the single GCD datapath instance.

Parameters:
WIDTH, 8, operand/result width in bits
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 1024, max cycles to wait for core_done after core_start (>=4)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  requester i has an operand pair pending; held until accepted
req_a  in  N_REQ*WIDTH  packed operand a, requester i at bits [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  packed operand b, same packing
req_ready  out  N_REQ  one-hot accept pulse, 1 cycle
rsp_valid  out  N_REQ  one-hot response pulse to the granted requester, 1 cycle
rsp_result  out  WIDTH  result, valid only while any rsp_valid bit is high
rsp_error  out  1  timeout flag, qualified by rsp_valid
busy  out  1  high in any state other than IDLE
core_start  out  1  one-cycle start pulse to GCD core
core_a  out  WIDTH  latched operand a to core
core_b  out  WIDTH  latched operand b to core
core_done  in  1  core completion (may be level; see WAIT rule)
core_result  in  WIDTH  core result, sampled when core_done accepted

Behaviour:
- Clock clk; reset is synchronous, active-high. On reset: state=IDLE, rr pointer=0, all outputs 0, timeout counter 0. Reset mid-operation abandons the transaction with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE arbitration: search from ptr, ptr+1, ... wrapping mod N_REQ; the first i with req_valid[i]=1 wins.
  - On a win: req_ready[i]=1 that cycle. Latch a_i, b_i and grant index. Set ptr=(i+1) mod N_REQ.
  - No valid request: stay in IDLE, ptr unchanged.
- Zero bypass on acceptance: if a==0 or b==0, skip the core. Result = a|b, so gcd(0,b)=b and gcd(0,0)=0. Next state RESP, error=0.
- Otherwise next state ISSUE.
- ISSUE: core_start=1 for exactly one cycle; core_a/core_b hold the latched operands from ISSUE through WAIT. Next state WAIT; counter cleared.
- WAIT: counter increments every cycle.
  - core_done is ignored in the first WAIT cycle, which guards against stale done held from the previous op.
  - From the second WAIT cycle on, core_done=1: capture core_result, error=0, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES without done: result=0, error=1, go to RESP.
  - core_done arriving in the same cycle the counter hits the limit: done wins, error=0.
- RESP: rsp_valid[grant]=1 for one cycle with rsp_result/rsp_error. Next state IDLE. New arbitration starts in the following cycle, so there is no back-to-back accept in RESP.
- Latency:
  - Core path: accept at T, core_start at T+1, done accepted at D>=T+3, rsp_valid at D+1.
  - Bypass: accept at T, rsp_valid at T+1.
- Requests arriving or dropping while busy are not observed until IDLE. Dropping req_valid before acceptance is allowed.
- core_start is never asserted outside ISSUE. At most one transaction is in flight.

Test Plan:
- Single request: reset 10 cycles; req 0 a=12, b=18 with a behavioural core (done 5 cycles after start) -> req_ready[0] once, one core_start, rsp_valid=0001 with result 6, error 0.
- Round robin: all 4 requesters hold valid from reset release, a=i+2, b=2(i+2) -> grants in order 0,1,2,3,0. Each rsp_valid matches its grantee with result i+2.
- Zero bypass: req 2 with a=0, b=9 -> no core_start, rsp_valid=0100 with result 9 one cycle after req_ready. Then a=0, b=0 -> result 0.
- Timeout: core never raises done, TIMEOUT_CYCLES=16 -> rsp_error=1, result 0 sixteen WAIT cycles after start. Arbiter then returns to IDLE and serves the next request normally.
- Stale done: core_done held high constantly -> done ignored in the first WAIT cycle. Response arrives in the second WAIT cycle with the captured core_result, never in ISSUE.
- Reset mid-WAIT: assert reset for one cycle during WAIT -> no rsp_valid, busy=0, core_start=0. Next request is granted starting from ptr=0.
